// File: rtl/secp256k1_pkg.sv
// secp256k1 constants, point/state types and the mod-p field helpers shared by
// point_double, point_add and the scalar_mult controller.
package secp256k1_pkg;

  localparam logic [255:0] P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  typedef struct packed {
    logic [255:0] x;
    logic [255:0] y;
  } point_t;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DBL, S_ADD, S_DONE} state_t;

  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] d;
    d = a - b;
    if (a < b) d = d + P;
    return d;
  endfunction

  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] prod;
    logic [511:0] rem;
    prod = {256'b0, a} * {256'b0, b};
    rem  = prod % {256'b0, P};
    return rem[255:0];
  endfunction

  // Fermat inverse a^(p-2); maps 0 to 0, callers screen that case out.
  function automatic logic [255:0] finv(input logic [255:0] a);
    logic [255:0] e;
    logic [255:0] r;
    e = P - 256'd2;
    r = 256'd1;
    for (int unsigned i = 0; i < 256; i++) begin
      r = fmul(r, r);
      if (e[255]) r = fmul(r, a);
      e = e << 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/point_double.sv
// Combinational affine point doubling on secp256k1 (y = 0 gives a meaningless
// result; the controller detects that case and flags infinity instead).
module point_double
  import secp256k1_pkg::*;
(
  input  logic [255:0] x_i,
  input  logic [255:0] y_i,
  output logic [255:0] x_o,
  output logic [255:0] y_o
);

  logic [255:0] lam;
  logic [255:0] x3;

  always_comb begin
    lam = fmul(fmul(256'd3, fmul(x_i, x_i)), finv(fadd(y_i, y_i)));
    x3  = fsub(fmul(lam, lam), fadd(x_i, x_i));
    x_o = x3;
    y_o = fsub(fmul(lam, fsub(x_i, x3)), y_i);
  end

endmodule

// File: rtl/scalar_mult_point_add.sv
// Combinational affine chord addition on secp256k1; assumes x1 != x2.
module point_add
  import secp256k1_pkg::*;
(
  input  logic [255:0] x1_i,
  input  logic [255:0] y1_i,
  input  logic [255:0] x2_i,
  input  logic [255:0] y2_i,
  output logic [255:0] x_o,
  output logic [255:0] y_o
);

  logic [255:0] lam;
  logic [255:0] x3;

  always_comb begin
    lam = fmul(fsub(y2_i, y1_i), finv(fsub(x2_i, x1_i)));
    x3  = fsub(fsub(fmul(lam, lam), x1_i), x2_i);
    x_o = x3;
    y_o = fsub(fmul(lam, fsub(x1_i, x3)), y1_i);
  end

endmodule

// File: rtl/scalar_mult.sv
// MSB-first double-and-add R = k*P controller on secp256k1 with start/done handshake.
// Define SCALAR_MULT_CONST_TIME_EN for the fixed-latency DBL+ADD-per-bit schedule.
module scalar_mult
  import secp256k1_pkg::*;
#(
  parameter int unsigned OP_WAIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] k,
  input  logic [255:0] px,
  input  logic [255:0] py,
  output logic         busy,
  output logic         done,
  output logic [255:0] rx,
  output logic [255:0] ry,
  output logic         r_inf
);

`ifdef SCALAR_MULT_CONST_TIME_EN
  localparam state_t BIT_ENTRY  = S_DBL;
  localparam bit     ALWAYS_ADD = 1'b1;
`else
  localparam state_t BIT_ENTRY  = S_SCAN;
  localparam bit     ALWAYS_ADD = 1'b0;
`endif

  localparam logic [15:0] WAIT_LAST = 16'(OP_WAIT - 1);

  state_t       state_q, state_d;
  logic [255:0] k_q, k_d;
  point_t       p_q, p_d;
  point_t       acc_q, acc_d;
  logic         ainf_q, ainf_d;
  logic [7:0]   idx_q, idx_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [255:0] rx_q, rx_d;
  logic [255:0] ry_q, ry_d;
  logic         rinf_q, rinf_d;

  point_t dbl_pt;
  point_t add_pt;
  logic   last;
  logic   kbit;
  logic   adv;

  point_double u_dbl (
    .x_i (acc_q.x),
    .y_i (acc_q.y),
    .x_o (dbl_pt.x),
    .y_o (dbl_pt.y)
  );

  point_add u_add (
    .x1_i (acc_q.x),
    .y1_i (acc_q.y),
    .x2_i (p_q.x),
    .y2_i (p_q.y),
    .x_o  (add_pt.x),
    .y_o  (add_pt.y)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    acc_d   = acc_q;
    ainf_d  = ainf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rinf_d  = rinf_q;
    adv     = 1'b0;
    last    = (cnt_q == WAIT_LAST);
    kbit    = k_q[idx_q];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = k;
          p_d     = '{x: px, y: py};
          ainf_d  = 1'b1;
          idx_d   = 8'd255;
          cnt_d   = '0;
          state_d = BIT_ENTRY;
        end
      end
      S_SCAN: begin
        if (ainf_q) begin
          if (kbit) begin
            acc_d  = p_q;
            ainf_d = 1'b0;
          end
          adv = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = S_DBL;
        end
      end
      S_DBL: begin
        if (!last) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          if (!ainf_q) begin
            if (acc_q.y == '0) ainf_d = 1'b1;
            else               acc_d  = dbl_pt;
          end
          if (kbit || ALWAYS_ADD) state_d = S_ADD;
          else                    adv     = 1'b1;
        end
      end
      S_ADD: begin
        if (!last) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          // Only reachable with kbit=0 in the constant-time schedule: result dropped.
          if (kbit) begin
            if (ainf_q) begin
              acc_d  = p_q;
              ainf_d = 1'b0;
            end else if (acc_q.x == p_q.x) begin
              if (acc_q.y == p_q.y) begin
                if (acc_q.y == '0) ainf_d = 1'b1;
                else               acc_d  = dbl_pt;
              end else begin
                ainf_d = 1'b1;
              end
            end else begin
              acc_d = add_pt;
            end
          end
          adv = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (idx_q == 8'd0) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q - 8'd1;
        state_d = BIT_ENTRY;
      end
    end

    // Result registers load on entry to DONE so they are valid with the done pulse.
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    if (done_d) begin
      rx_d   = ainf_d ? '0 : acc_d.x;
      ry_d   = ainf_d ? '0 : acc_d.y;
      rinf_d = ainf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      ainf_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      rinf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      ainf_q  <= ainf_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rinf_q  <= rinf_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rx    = rx_q;
  assign ry    = ry_q;
  assign r_inf = rinf_q;

endmodule

// File: tb/tb_scalar_mult.sv
// Directed testbench for scalar_mult; builds the constant-time variant when
// SCALAR_MULT_CONST_TIME_EN is defined.
module tb_scalar_mult;
  import secp256k1_pkg::*;

`ifdef SCALAR_MULT_CONST_TIME_EN
  localparam int W = 2;
`else
  localparam int W = 1;
`endif
  localparam int MAXC = 3000;

  localparam logic [255:0] FP   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] G2X  = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [255:0] G2Y  = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
  localparam logic [255:0] G3X  = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
  localparam logic [255:0] G3Y  = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;
  localparam logic [255:0] NORD = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] k = '0;
  logic [255:0] px = GX;
  logic [255:0] py = GY;
  logic         busy, done, r_inf;
  logic [255:0] rx, ry;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scalar_mult #(.OP_WAIT(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .k     (k),
    .px    (px),
    .py    (py),
    .busy  (busy),
    .done  (done),
    .rx    (rx),
    .ry    (ry),
    .r_inf (r_inf)
  );

  // Called at a negedge; returns the done cycle as an offset from the accept cycle.
  task automatic run_op(input logic [255:0] kv, input bit hold, input logic [255:0] kalt,
                        output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    start = 1'b1;
    k = kv;
    @(posedge clk);
    for (int n = 1; n <= MAXC; n++) begin
      @(negedge clk);
      if (hold) begin
        start = 1'b1;
        k = kalt;
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  function automatic int exp_lat(input logic [255:0] kv);
    int m, pc;
    logic [255:0] t;
    m = -1;
    pc = 0;
    t = kv;
    for (int i = 0; i < 256; i++) begin
      if (t[0]) begin
        pc++;
        m = i;
      end
      t = t >> 1;
    end
    if (m < 0) return 257;
    return 256 + W * (m + pc - 1) + 1;
  endfunction

  function automatic bit on_curve(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] y2, x2, x3;
    y2 = ({256'b0, y} * {256'b0, y}) % {256'b0, FP};
    x2 = ({256'b0, x} * {256'b0, x}) % {256'b0, FP};
    x3 = (x2 * {256'b0, x} + 512'd7) % {256'b0, FP};
    return y2 == x3;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, r_inf} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags busy/done/r_inf got=%b exp=000", {busy, done, r_inf});
    end
    checks++;
    if (rx !== '0 || ry !== '0) begin
      failures++;
      $display("FAIL reset_result got rx=%h ry=%h exp=0", rx, ry);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

`ifndef SCALAR_MULT_CONST_TIME_EN
  task automatic test_k1();
    int lat;
    bit bok;
    run_op(256'd1, 1'b0, '0, lat, bok);
    checks++;
    if (lat !== 257) begin failures++; $display("FAIL k1_latency got=%0d exp=257", lat); end
    checks++;
    if (!bok) begin failures++; $display("FAIL k1_busy got=0 exp=1 during run"); end
    checks++;
    if (rx !== GX || ry !== GY || r_inf !== 1'b0) begin
      failures++;
      $display("FAIL k1_result got rx=%h ry=%h inf=%b exp rx=%h ry=%h inf=0", rx, ry, r_inf, GX, GY);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL k1_after_done busy/done got=%b exp=00", {busy, done});
    end
    checks++;
    if (rx !== GX) begin failures++; $display("FAIL k1_hold got rx=%h exp=%h", rx, GX); end
  endtask

  task automatic test_k2_k3();
    int lat;
    bit bok;
    run_op(256'd2, 1'b0, '0, lat, bok);
    checks++;
    if (lat !== 258) begin failures++; $display("FAIL k2_latency got=%0d exp=258", lat); end
    checks++;
    if (rx !== G2X || ry !== G2Y || r_inf !== 1'b0) begin
      failures++;
      $display("FAIL k2_result got rx=%h ry=%h inf=%b exp rx=%h ry=%h", rx, ry, r_inf, G2X, G2Y);
    end
    @(negedge clk);
    run_op(256'd3, 1'b0, '0, lat, bok);
    checks++;
    if (lat !== 259) begin failures++; $display("FAIL k3_latency got=%0d exp=259", lat); end
    checks++;
    if (rx !== G3X || ry !== G3Y || r_inf !== 1'b0) begin
      failures++;
      $display("FAIL k3_result got rx=%h ry=%h inf=%b exp rx=%h ry=%h", rx, ry, r_inf, G3X, G3Y);
    end
    @(negedge clk);
  endtask

  task automatic test_k0_order();
    int lat;
    bit bok;
    run_op(256'd0, 1'b0, '0, lat, bok);
    checks++;
    if (lat !== 257) begin failures++; $display("FAIL k0_latency got=%0d exp=257", lat); end
    checks++;
    if (r_inf !== 1'b1 || rx !== '0 || ry !== '0) begin
      failures++;
      $display("FAIL k0_result got inf=%b rx=%h ry=%h exp inf=1 rx=0 ry=0", r_inf, rx, ry);
    end
    @(negedge clk);
    run_op(NORD, 1'b0, '0, lat, bok);
    checks++;
    if (lat !== exp_lat(NORD)) begin
      failures++;
      $display("FAIL korder_latency got=%0d exp=%0d", lat, exp_lat(NORD));
    end
    checks++;
    if (r_inf !== 1'b1 || rx !== '0 || ry !== '0) begin
      failures++;
      $display("FAIL korder_result got inf=%b rx=%h ry=%h exp inf=1 rx=0 ry=0", r_inf, rx, ry);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    int ndone;
    bit bok;
    start = 1'b1;
    k = NORD;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL midreset_immediate busy/done got=%b exp=00", {busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (700) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) ndone++;
    end
    checks++;
    if (ndone !== 0) begin failures++; $display("FAIL midreset_quiet got=%0d busy/done cycles exp=0", ndone); end
    run_op(256'd2, 1'b0, '0, lat, bok);
    checks++;
    if (lat !== 258 || rx !== G2X || ry !== G2Y) begin
      failures++;
      $display("FAIL midreset_restart got lat=%0d rx=%h exp lat=258 rx=%h", lat, rx, G2X);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bok;
    run_op(256'd2, 1'b1, 256'd3, lat, bok);
    checks++;
    if (lat !== 258 || rx !== G2X || ry !== G2Y) begin
      failures++;
      $display("FAIL busy_ignore got lat=%0d rx=%h exp lat=258 rx=%h", lat, rx, G2X);
    end
    start = 1'b1;
    k = 256'd1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL done_cycle_start got busy=%b exp=0", busy); end
    run_op(256'd1, 1'b0, '0, lat, bok);
    checks++;
    if (lat !== 257 || rx !== GX || ry !== GY) begin
      failures++;
      $display("FAIL b2b_result got lat=%0d rx=%h exp lat=257 rx=%h", lat, rx, GX);
    end
    @(negedge clk);
  endtask
`else
  task automatic test_ct();
    int lat;
    bit bok;
    run_op(256'd1, 1'b0, '0, lat, bok);
    checks++;
    if (lat !== 1025) begin failures++; $display("FAIL ct_k1_latency got=%0d exp=1025", lat); end
    checks++;
    if (rx !== GX || ry !== GY || r_inf !== 1'b0 || !bok) begin
      failures++;
      $display("FAIL ct_k1_result got rx=%h ry=%h inf=%b busy_ok=%b", rx, ry, r_inf, bok);
    end
    @(negedge clk);
    run_op(256'd1 << 255, 1'b0, '0, lat, bok);
    checks++;
    if (lat !== 1025) begin failures++; $display("FAIL ct_k2p255_latency got=%0d exp=1025", lat); end
    checks++;
    if (r_inf !== 1'b0 || !on_curve(rx, ry) || rx === GX || rx === G2X) begin
      failures++;
      $display("FAIL ct_k2p255_result got rx=%h ry=%h inf=%b (must be finite point on curve)", rx, ry, r_inf);
    end
    @(negedge clk);
    run_op(256'd2, 1'b1, 256'd3, lat, bok);
    start = 1'b0;
    checks++;
    if (lat !== 1025 || rx !== G2X || ry !== G2Y) begin
      failures++;
      $display("FAIL ct_busy_ignore got lat=%0d rx=%h exp lat=1025 rx=%h", lat, rx, G2X);
    end
    @(negedge clk);
    run_op(256'd3, 1'b0, '0, lat, bok);
    checks++;
    if (lat !== 1025 || rx !== G3X || ry !== G3Y) begin
      failures++;
      $display("FAIL ct_k3 got lat=%0d rx=%h exp lat=1025 rx=%h", lat, rx, G3X);
    end
    @(negedge clk);
    run_op(256'd0, 1'b0, '0, lat, bok);
    checks++;
    if (lat !== 1025 || r_inf !== 1'b1 || rx !== '0) begin
      failures++;
      $display("FAIL ct_k0 got lat=%0d inf=%b rx=%h exp lat=1025 inf=1 rx=0", lat, r_inf, rx);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
`ifndef SCALAR_MULT_CONST_TIME_EN
    test_k1();
    test_k2_k3();
    test_k0_order();
    test_reset_mid();
    test_back_to_back();
`else
    test_ct();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
